// File: rtl/count_pwm_gen.sv
// count_pwm_gen: turns a free-running 4-bit count into a PWM waveform.
// Duty updates arrive over valid/ready and are double-buffered. A new duty
// only takes effect at a period boundary, either a wrap (15 -> 0) or a
// counter restart to 0, so every PWM period is glitch-free. Completed wraps
// are pulsed on wrap_pulse and counted modulo 256 in period_cnt.
module count_pwm_gen (
    input  logic       clk,
    input  logic       reset,       // synchronous, active-low
    input  logic [3:0] count,
    input  logic [3:0] duty_in,
    input  logic       duty_valid,
    output logic       duty_ready,
    output logic       pwm_out,
    output logic       wrap_pulse,
    output logic [7:0] period_cnt
);

    localparam logic [3:0] COUNT_MAX = 4'd15;

    logic [3:0] prev_count_q,  prev_count_d;
    logic [3:0] active_duty_q, active_duty_d;
    logic [3:0] pend_duty_q,   pend_duty_d;
    logic       pend_flag_q,   pend_flag_d;
    logic       pwm_q,         pwm_d;
    logic       wrap_q,        wrap_d;
    logic [7:0] period_cnt_q,  period_cnt_d;

    logic       period_start;
    logic       is_wrap;
    logic       xfer;
    logic [3:0] eff_duty;

    // Boundary detection, handshake and next-state for every register.
    always_comb begin
        // NOTE: every variable gets a default before any condition, so no
        // path leaves a value unassigned and no latch is inferred.
        prev_count_d  = count;
        active_duty_d = active_duty_q;
        pend_duty_d   = pend_duty_q;
        pend_flag_d   = pend_flag_q;
        period_cnt_d  = period_cnt_q;

        // A held count (stall) keeps prev == count, so it never looks like
        // a boundary; likewise the first sample after reset at count 0.
        period_start = (count == 4'd0) && (prev_count_q != 4'd0);
        is_wrap      = period_start && (prev_count_q == COUNT_MAX);

        // The pending slot is single-entry: refuse while it is occupied.
        duty_ready = !pend_flag_q;
        xfer       = duty_valid && duty_ready;

        // A value committed at this boundary already governs count 0.
        eff_duty = (period_start && pend_flag_q) ? pend_duty_q : active_duty_q;

        if (period_start && pend_flag_q) begin
            active_duty_d = pend_duty_q;
            pend_flag_d   = 1'b0;
        end

        // Transfers only happen with the slot empty, so they never collide
        // with a commit; a transfer on a boundary waits for the next one.
        if (xfer) begin
            pend_duty_d = duty_in;
            pend_flag_d = 1'b1;
        end

        pwm_d  = (count < eff_duty);
        wrap_d = is_wrap;
        if (is_wrap) begin
            period_cnt_d = period_cnt_q + 8'd1;
        end
    end

    // State registers with synchronous active-low reset; a pending duty is
    // discarded by reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            prev_count_q  <= 4'd0;
            active_duty_q <= 4'd0;
            pend_duty_q   <= 4'd0;
            pend_flag_q   <= 1'b0;
            pwm_q         <= 1'b0;
            wrap_q        <= 1'b0;
            period_cnt_q  <= 8'd0;
        end else begin
            prev_count_q  <= prev_count_d;
            active_duty_q <= active_duty_d;
            pend_duty_q   <= pend_duty_d;
            pend_flag_q   <= pend_flag_d;
            pwm_q         <= pwm_d;
            wrap_q        <= wrap_d;
            period_cnt_q  <= period_cnt_d;
        end
    end

    assign pwm_out    = pwm_q;
    assign wrap_pulse = wrap_q;
    assign period_cnt = period_cnt_q;

endmodule

// File: tb/tb_count_pwm_gen.sv
// Self-checking bench for count_pwm_gen: a table of reset / first-sample
// vectors, then directed period sequences with hand-derived expectations.
module tb_count_pwm_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count;
    logic [3:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       wrap_pulse;
    logic [7:0] period_cnt;

    int   n_checks   = 0;
    int   n_pass     = 0;
    int   exp_period = 0;
    logic exp_ready  = 1'b1;

    count_pwm_gen dut (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .pwm_out    (pwm_out),
        .wrap_pulse (wrap_pulse),
        .period_cnt (period_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [3:0] c;
        logic [3:0] d;
        logic       v;
        logic       pwm;
        logic       wrap;
        logic [7:0] per;
        logic       rdy;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Drive inputs, let one rising edge sample them, then settle.
    task automatic step(input logic r, input logic [3:0] c, input logic [3:0] d,
                        input logic v);
        reset      = r;
        count      = c;
        duty_in    = d;
        duty_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input string tag, input logic [3:0] c, input logic [3:0] d,
                        input logic v, input logic e_pwm, input logic e_wrap,
                        input logic [7:0] e_per, input logic e_rdy);
        step(1'b1, c, d, v);
        check($sformatf("%s c=%0d pwm", tag, c),   pwm_out,    e_pwm);
        check($sformatf("%s c=%0d wrap", tag, c),  wrap_pulse, e_wrap);
        check($sformatf("%s c=%0d per", tag, c),   period_cnt, e_per);
        check($sformatf("%s c=%0d ready", tag, c), duty_ready, e_rdy);
    endtask

    // One full period 0..15 entered from count 15 (so count 0 is a wrap),
    // governed by duty_exp, with an optional transfer at count xfer_at.
    task automatic run_period(input string tag, input int duty_exp, input int xfer_at,
                              input logic [3:0] xfer_val);
        logic v;
        for (int c = 0; c < 16; c++) begin
            v = (c == xfer_at);
            if (c == 0) begin
                exp_period++;
                exp_ready = 1'b1;
            end
            if (v) exp_ready = 1'b0;
            tick(tag, 4'(c), v ? xfer_val : 4'd0, v, (c < duty_exp), (c == 0),
                 8'(exp_period), exp_ready);
        end
    endtask

    initial begin
        int wraps;
        int pwm_highs;
        logic [7:0] per_before_last;

        //           r     c      d      v     pwm   wrap  per    rdy
        vecs[0] = '{1'b0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
        vecs[1] = '{1'b0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
        vecs[2] = '{1'b1, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[3] = '{1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[4] = '{1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[5] = '{1'b1, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};

        // Reset with valid held, release at count 0 with a transfer, then a
        // held 0 that must not be taken as a period start.
        for (int i = 0; i < 6; i++) begin
            step(vecs[i].r, vecs[i].c, vecs[i].d, vecs[i].v);
            check($sformatf("vec%0d pwm", i),   pwm_out,    vecs[i].pwm);
            check($sformatf("vec%0d wrap", i),  wrap_pulse, vecs[i].wrap);
            check($sformatf("vec%0d per", i),   period_cnt, vecs[i].per);
            check($sformatf("vec%0d ready", i), duty_ready, vecs[i].rdy);
        end

        // Rest of the first period still runs with duty 0.
        exp_ready = 1'b0;
        for (int c = 3; c < 16; c++) tick("first", 4'(c), 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

        // Duty 4 commits at the first wrap: 4 high, 12 low, periods 1..3.
        run_period("duty4", 4, -1, 4'd0);
        run_period("duty4", 4, -1, 4'd0);
        run_period("duty4", 4, -1, 4'd0);

        // Backpressure: 10 accepted at count 5, then 3 held while not ready.
        exp_period = 4;
        tick("bp", 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 8'd4, 1'b1);
        for (int c = 1; c < 5; c++) tick("bp", 4'(c), 4'd0, 1'b0, (c < 4), 1'b0, 8'd4, 1'b1);
        tick("bp_xfer10", 4'd5, 4'd10, 1'b1, 1'b0, 1'b0, 8'd4, 1'b0);
        for (int c = 6; c < 16; c++) tick("bp_hold3", 4'(c), 4'd3, 1'b1, (c < 4), 1'b0, 8'd4, 1'b0);
        exp_period = 5;
        tick("duty10", 4'd0, 4'd3, 1'b1, 1'b1, 1'b1, 8'd5, 1'b1);
        tick("duty10_xfer3", 4'd1, 4'd3, 1'b1, 1'b1, 1'b0, 8'd5, 1'b0);
        for (int c = 2; c < 16; c++) tick("duty10", 4'(c), 4'd0, 1'b0, (c < 10), 1'b0, 8'd5, 1'b0);
        exp_ready = 1'b0;

        // Duty 3 period queues 0; duty 0 period queues 15; then duty 15.
        run_period("duty3", 3, 2, 4'd0);
        run_period("duty0", 0, 2, 4'd15);
        run_period("duty15", 15, -1, 4'd0);

        // Counter restart at 7 with 6 pending, then a stall at 5.
        exp_period = 9;
        tick("rs", 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 8'd9, 1'b1);
        for (int c = 1; c < 8; c++)
            tick("rs", 4'(c), (c == 3) ? 4'd6 : 4'd0, (c == 3), 1'b1, 1'b0, 8'd9, (c < 3));
        tick("restart", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 8'd9, 1'b1);
        for (int c = 1; c < 6; c++) tick("duty6", 4'(c), 4'd0, 1'b0, 1'b1, 1'b0, 8'd9, 1'b1);
        for (int i = 0; i < 4; i++) tick("stall", 4'd5, 4'd0, 1'b0, 1'b1, 1'b0, 8'd9, 1'b1);
        for (int c = 6; c < 16; c++) tick("duty6", 4'(c), 4'd0, 1'b0, 1'b0, 1'b0, 8'd9, 1'b1);
        run_period("duty6", 6, -1, 4'd0);

        // Reset mid-operation discards a pending duty.
        tick("pre_rst", 4'd1, 4'd9, 1'b1, 1'b1, 1'b0, 8'd10, 1'b0);
        step(1'b0, 4'd2, 4'd0, 1'b0);
        check("midrst pwm",   pwm_out,    0);
        check("midrst wrap",  wrap_pulse, 0);
        check("midrst per",   period_cnt, 0);
        check("midrst ready", duty_ready, 1);

        // Rollover: 256 wraps with active duty 0.
        step(1'b1, 4'd0, 4'd0, 1'b0);
        wraps           = 0;
        pwm_highs       = 0;
        per_before_last = 8'd0;
        for (int w = 0; w < 256; w++) begin
            for (int c = 1; c < 17; c++) begin
                step(1'b1, 4'(c), 4'd0, 1'b0);
                if (wrap_pulse) wraps++;
                if (pwm_out) pwm_highs++;
                if (w == 255 && c == 15) per_before_last = period_cnt;
            end
            if (w == 0) check("roll first per", period_cnt, 1);
        end
        check("roll per_255",    per_before_last, 255);
        check("roll per_final",  period_cnt,      0);
        check("roll wraps",      wraps,           256);
        check("roll pwm_highs",  pwm_highs,       0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
